// File: rtl/pipe_register_if.sv
// Handshake/data bundle for pipe_register: "slave" is the pipe's view, "master" the driver's.
interface pipe_register_if #(
  parameter int unsigned size  = 8,
  parameter int unsigned depth = 3
);
  localparam int unsigned CntW = $clog2(depth + 1);

  logic            enable;
  logic            flush;
  logic            inValid;
  logic [size-1:0] regIn;
  logic            inReady;
  logic            outValid;
  logic [size-1:0] regOut;
  logic            outReady;
  logic [CntW-1:0] count;

  modport slave (
    input  enable, flush, inValid, regIn, outReady,
    output inReady, outValid, regOut, count
  );

  modport master (
    output enable, flush, inValid, regIn, outReady,
    input  inReady, outValid, regOut, count
  );
endinterface

// File: rtl/pipe_register.sv
// depth-stage elastic pipeline register with valid/ready handshake, bubble collapsing,
// freeze and flush. Define PIPE_REG_BYPASS_EN for a zero-latency path through an empty pipe.
module pipe_register #(
  parameter int unsigned size  = 8,
  parameter int unsigned depth = 3
) (
  input logic            clock,
  input logic            reset,
  pipe_register_if.slave bus
);
  localparam int unsigned CntW = $clog2(depth + 1);

  logic [size-1:0]  data_q [depth];
  logic [size-1:0]  data_d [depth];
  logic [depth-1:0] valid_q;
  logic [depth-1:0] valid_d;
  logic [depth-1:0] move;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             run;
  logic             out_valid_base;
  logic             in_ready;
  logic             in_xfer;

  assign run            = bus.enable & ~bus.flush;
  assign out_valid_base = run & valid_q[depth-1];

  // A stage advances when its successor is empty or emptying in the same cycle.
  always_comb begin
    logic nxt_free;
    move          = '0;
    move[depth-1] = out_valid_base & bus.outReady;
    nxt_free      = ~valid_q[depth-1] | move[depth-1];
    for (int i = int'(depth) - 2; i >= 0; i--) begin
      move[i]  = run & valid_q[i] & nxt_free;
      nxt_free = ~valid_q[i] | move[i];
    end
  end

  assign in_ready = ~reset & run & (~valid_q[0] | move[0]);

`ifdef PIPE_REG_BYPASS_EN
  logic bypass;
  assign bypass       = ~reset & run & bus.inValid & (count_q == '0);
  // A bypassed word accepted downstream never lands in stage 0.
  assign in_xfer      = bus.inValid & in_ready & ~(bypass & bus.outReady);
  assign bus.outValid = out_valid_base | bypass;
  assign bus.regOut   = bypass ? bus.regIn : data_q[depth-1];
`else
  assign in_xfer      = bus.inValid & in_ready;
  assign bus.outValid = out_valid_base;
  assign bus.regOut   = data_q[depth-1];
`endif

  assign bus.inReady = in_ready;
  assign bus.count   = count_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = '0;
    if (in_xfer) begin
      valid_d[0] = 1'b1;
      data_d[0]  = bus.regIn;
    end else begin
      valid_d[0] = valid_q[0] & ~move[0];
    end
    for (int i = 1; i < int'(depth); i++) begin
      if (move[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
      end else begin
        valid_d[i] = valid_q[i] & ~move[i];
      end
    end
    // Flush drops occupancy only; data registers keep their contents.
    if (bus.flush) begin
      valid_d = '0;
    end
    for (int i = 0; i < int'(depth); i++) begin
      count_d = count_d + CntW'(valid_d[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(depth); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < int'(depth); i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end
endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: directed vector table, hand sequences and a slot-model random run.
module tb_pipe_register;
  localparam int unsigned Size  = 8;
  localparam int unsigned Depth = 3;

  logic clock = 1'b0;
  logic reset;

  pipe_register_if #(.size(Size), .depth(Depth)) bus ();

  pipe_register #(.size(Size), .depth(Depth)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per stage, each holding an occupancy flag and its last word.
  bit       m_val [Depth];
  logic [7:0] m_dat [Depth];

  typedef struct {
    bit         en;
    bit         fl;
    bit         iv;
    logic [7:0] din;
    bit         ordy;
    bit         ov;
    logic [7:0] dout;
    bit         ir;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    foreach (m_val[i]) begin
      m_val[i] = 1'b0;
      m_dat[i] = '0;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    foreach (m_val[i]) c += int'(m_val[i]);
    return c;
  endfunction

  function automatic bit m_bypass();
`ifdef PIPE_REG_BYPASS_EN
    return !reset && bus.enable && !bus.flush && bus.inValid && (m_count() == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_out_valid();
    return m_bypass() || (bus.enable && !bus.flush && m_val[Depth-1]);
  endfunction

  function automatic int m_reg_out();
    return m_bypass() ? int'(bus.regIn) : int'(m_dat[Depth-1]);
  endfunction

  // Slot 0 is free this cycle if, after letting every word slide forward, it ends up empty.
  function automatic bit m_in_ready();
    bit v [Depth];
    if (!bus.enable || bus.flush) return 1'b0;
    v = m_val;
    if (v[Depth-1] && bus.outReady) v[Depth-1] = 1'b0;
    for (int i = int'(Depth) - 2; i >= 0; i--) begin
      if (v[i] && !v[i+1]) begin
        v[i+1] = 1'b1;
        v[i]   = 1'b0;
      end
    end
    return !v[0];
  endfunction

  task automatic m_step();
    bit acc  = m_in_ready() && bus.inValid;
    bit thru = m_bypass() && bus.outReady;
    if (bus.flush) begin
      foreach (m_val[i]) m_val[i] = 1'b0;
      return;
    end
    if (!bus.enable) return;
    if (m_val[Depth-1] && bus.outReady) m_val[Depth-1] = 1'b0;
    for (int i = int'(Depth) - 2; i >= 0; i--) begin
      if (m_val[i] && !m_val[i+1]) begin
        m_val[i+1] = 1'b1;
        m_val[i]   = 1'b0;
        m_dat[i+1] = m_dat[i];
      end
    end
    if (acc && !thru) begin
      m_val[0] = 1'b1;
      m_dat[0] = bus.regIn;
    end
  endtask

  task automatic drive(input bit en, input bit fl, input bit iv, input logic [7:0] din,
                       input bit ordy);
    bus.enable   = en;
    bus.flush    = fl;
    bus.inValid  = iv;
    bus.regIn    = din;
    bus.outReady = ordy;
  endtask

  task automatic tick();
    @(posedge clock);
    m_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    @(negedge clock);
    chk($sformatf("%s.outValid", tag), int'(bus.outValid), int'(m_out_valid()));
    chk($sformatf("%s.regOut", tag), int'(bus.regOut), m_reg_out());
    chk($sformatf("%s.inReady", tag), int'(bus.inReady), int'(m_in_ready()));
    chk($sformatf("%s.count", tag), int'(bus.count), m_count());
  endtask

  task automatic add_vec(input bit en, input bit fl, input bit iv, input int din,
                         input bit ordy, input bit ov, input int dout, input bit ir,
                         input int cnt);
    vec_t v;
    v.en = en; v.fl = fl; v.iv = iv; v.din = 8'(din); v.ordy = ordy;
    v.ov = ov; v.dout = 8'(dout); v.ir = ir; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    m_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("reset.outValid", int'(bus.outValid), 0);
    chk("reset.regOut", int'(bus.regOut), 0);
    chk("reset.inReady", int'(bus.inReady), 0);
    chk("reset.count", int'(bus.count), 0);
    reset = 1'b0;

`ifndef PIPE_REG_BYPASS_EN
    // Stream / latency: en fl iv din ordy | ov dout ir cnt
    add_vec(1, 0, 1, 97, 1,  0, 0, 1, 0);
    add_vec(1, 0, 1, 98, 1,  0, 0, 1, 1);
    add_vec(1, 0, 1, 99, 1,  0, 0, 1, 2);
    add_vec(1, 0, 1, 100, 1, 1, 97, 1, 3);
    add_vec(1, 0, 0, 0, 1,   1, 98, 1, 3);
    add_vec(1, 0, 0, 0, 1,   1, 99, 1, 2);
    add_vec(1, 0, 0, 0, 1,   1, 100, 1, 1);
    add_vec(1, 0, 0, 0, 1,   0, 100, 1, 0);
    // Backpressure: fill to three, fourth refused, then simultaneous in/out
    add_vec(1, 0, 1, 97, 0,  0, 100, 1, 0);
    add_vec(1, 0, 1, 98, 0,  0, 100, 1, 1);
    add_vec(1, 0, 1, 99, 0,  0, 100, 1, 2);
    add_vec(1, 0, 1, 100, 0, 1, 97, 0, 3);
    add_vec(1, 0, 1, 100, 1, 1, 97, 1, 3);
    add_vec(1, 0, 0, 0, 1,   1, 98, 1, 3);
    add_vec(1, 0, 0, 0, 1,   1, 99, 1, 2);
    add_vec(1, 0, 0, 0, 1,   1, 100, 1, 1);
    // Bubble collapse: 10, two idles, 20, stalled output
    add_vec(1, 0, 1, 10, 0,  0, 100, 1, 0);
    add_vec(1, 0, 0, 0, 0,   0, 100, 1, 1);
    add_vec(1, 0, 0, 0, 0,   0, 100, 1, 1);
    add_vec(1, 0, 1, 20, 0,  1, 10, 1, 1);
    add_vec(1, 0, 0, 0, 0,   1, 10, 1, 2);
    add_vec(1, 0, 0, 0, 0,   1, 10, 1, 2);
    add_vec(1, 0, 0, 0, 0,   1, 10, 1, 2);
    add_vec(1, 0, 0, 0, 1,   1, 10, 1, 2);
    add_vec(1, 0, 0, 0, 1,   1, 20, 1, 1);
    // Freeze then flush
    add_vec(1, 0, 1, 5, 0,   0, 20, 1, 0);
    add_vec(1, 0, 1, 6, 0,   0, 20, 1, 1);
    add_vec(1, 0, 1, 7, 0,   0, 20, 1, 2);
    for (int k = 0; k < 4; k++) add_vec(0, 0, 1, 9, 1, 0, 5, 0, 3);
    add_vec(1, 1, 1, 9, 1,   0, 5, 0, 3);
    add_vec(1, 0, 0, 0, 1,   0, 5, 1, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].en, vecs[k].fl, vecs[k].iv, vecs[k].din, vecs[k].ordy);
      @(negedge clock);
      chk($sformatf("vec%0d.outValid", k), int'(bus.outValid), int'(vecs[k].ov));
      chk($sformatf("vec%0d.regOut", k), int'(bus.regOut), int'(vecs[k].dout));
      chk($sformatf("vec%0d.inReady", k), int'(bus.inReady), int'(vecs[k].ir));
      chk($sformatf("vec%0d.count", k), int'(bus.count), vecs[k].cnt);
      tick();
    end
`else
    // Empty pipe, downstream ready: word passes straight through.
    drive(1'b1, 1'b0, 1'b1, 8'd42, 1'b1);
    #1;
    chk("bypass.outValid", int'(bus.outValid), 1);
    chk("bypass.regOut", int'(bus.regOut), 42);
    chk("bypass.inReady", int'(bus.inReady), 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    check_model("bypass_after");
    chk("bypass.count", int'(bus.count), 0);
    tick();
    // Empty pipe, downstream stalled: word is shown and also captured in stage 0.
    drive(1'b1, 1'b0, 1'b1, 8'd43, 1'b0);
    check_model("bypass_stall");
    chk("bypass_stall.regOut", int'(bus.regOut), 43);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check_model("bypass_stall_after");
    chk("bypass_stall.count", int'(bus.count), 1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
`endif

    // Asynchronous reset with three words in flight.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(200 + k), 1'b0);
      check_model($sformatf("fill%0d", k));
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 8'd55, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.outValid", int'(bus.outValid), 0);
    chk("midreset.regOut", int'(bus.regOut), 0);
    chk("midreset.count", int'(bus.count), 0);
    chk("midreset.inReady", int'(bus.inReady), 0);
    m_clear();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_model("post_reset");
    chk("post_reset.inReady", int'(bus.inReady), 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check_model("post_reset_accept");
    chk("post_reset.count", int'(bus.count), 1);
    tick();

    // Randomized traffic against the slot model.
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
            8'($urandom), (n % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0));
      check_model($sformatf("rand%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised successor to the single enable register: a `depth`-stage elastic pipeline register of `size` bits per stage.
- Valid/ready handshake on both sides, bubble collapsing, global enable (freeze) and synchronous flush.
- Sits between datapath blocks that need a fixed nominal latency but must tolerate downstream stalls without losing data.

Parameters:
- size, 8, data width in bits per stage.
- depth, 3, number of pipeline stages (legal range 1..16).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, global advance; 0 freezes every stage.
- flush, input, 1, synchronous clear of all valid bits.
- inValid, input, 1, upstream offers regIn.
- regIn, input, size, input data.
- inReady, output, 1, stage 0 can accept this cycle.
- outValid, output, 1, last stage holds data and the block is enabled.
- regOut, output, size, data of last stage.
- outReady, input, 1, downstream accepts.
- count, output, clog2(depth+1), number of occupied stages.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset asserted forces immediately, with no clock needed:
  - all valid[i]=0, all data[i]=0;
  - regOut=0, outValid=0, inReady=0 while reset is high, count=0.
- Stages: index 0 is the input stage, depth-1 is the output stage. Each stage holds a data register and a valid bit.
- Output side:
  - outValid = enable & valid[depth-1] & ~flush.
  - regOut = data[depth-1] at all times. It is not gated by valid and holds stale data when empty.
  - Output transfer: outValid & outReady at the rising edge.
- Advance terms:
  - move[depth-1] = outValid & outReady.
  - For i<depth-1: move[i] = enable & valid[i] & (~valid[i+1] | move[i+1]). This is bubble collapsing: a stage advances into an empty or simultaneously emptying successor.
- Input side:
  - inReady = enable & ~flush & (~valid[0] | move[0]). Combinational; inReady does not depend on inValid.
  - Input transfer: inValid & inReady. On transfer, data[0]<=regIn and valid[0]<=1.
- Per-stage update at the edge:
  - valid[i] <= (incoming transfer into i) | (valid[i] & ~move[i]).
  - data[i] loads only on an incoming transfer; otherwise it holds.
- Latency: with outReady=1, enable=1 and an empty pipe, a word accepted at edge N appears with outValid=1 after edge N+depth-1. That is depth cycles of register latency, counting the input edge.
- Throughput: one word per cycle sustained while outReady=1.
- Full: count==depth and outReady=0 gives inReady=0. Full with outReady=1 gives inReady=1, with simultaneous in and out transfer.
- enable=0: no stage moves, no transfer on either side, and count is frozen. Data is preserved; nothing is lost.
- flush=1 (synchronous, priority over everything except reset):
  - at the edge all valid<=0;
  - input is not accepted (inReady=0) and outValid=0 that cycle;
  - data registers hold;
  - count=0 from the next cycle.
- count: registered popcount of valid bits, updated at the same edge as the valid bits. It never exceeds depth and never wraps.
- Reset mid-operation: all state clears instantly, and the in-flight words are discarded.
- depth=1 degenerates to a single-entry skid-free register with handshake.

Optional Feature:
- Macro: PIPE_REG_BYPASS_EN.
- When defined: if count==0, enable=1, flush=0 and inValid=1:
  - outValid=1 and regOut=regIn combinationally;
  - if outReady=1 the word transfers straight through, zero latency, and no stage is loaded;
  - if outReady=0 the word enters stage 0 normally.
  - inReady is unchanged.
- When undefined: no combinational path from input to output; the behaviour is exactly as above.

Test Plan (size=8, depth=3, bypass undefined unless stated):
- Reset check: reset pulsed high mid-simulation with 3 words in flight -> regOut=0, outValid=0 and count=0 immediately, without waiting for a clock edge; after release the pipe accepts again.
- Latency and stream: outReady=1, inValid=1 with regIn=97,98,99 on consecutive edges -> outValid=1 with regOut=97 after the 3rd edge, then 98 and 99 on the following edges; count reaches 3 and stays there for the whole stream.
- Backpressure: outReady=0, push 97,98,99,100 -> first 3 accepted, count=3, inReady=0 on the 4th. Then outReady=1 -> 97 out, 100 accepted on the same edge, order 97,98,99,100 preserved.
- Bubble collapse: push 10, idle 2 cycles, push 20, hold outReady=0 -> count=2, with 10 in stage 2 and 20 in stage 1 after 2 more edges.
- Freeze and flush: pipe holds 5,6,7, enable=0 for 4 cycles -> count=3 and regOut unchanged, no transfers. Then flush=1 for 1 cycle -> outValid=0 and inReady=0 that cycle, count=0 after.
- Bypass (PIPE_REG_BYPASS_EN defined): empty pipe, inValid=1, regIn=42, outReady=1 -> same cycle outValid=1, regOut=42, count stays 0.
